// File: rtl/nn_pkg.sv
// Shared constants and FSM state type for the digit-classifier capture front end.
// Bitmap geometry follows the 28x28 input layer of the network.
package nn_pkg;
   localparam int IMG_DIM  = 28;
   localparam int IMG_BITS = IMG_DIM * IMG_DIM;
   localparam int PRED_W   = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURE,
      ST_START,
      ST_WAIT_NN
   } cap_state_t;
endpackage

// File: rtl/nn_image_capture_cell_accumulator.sv
// Per-column ink counters for one band of cells; resolves a cell bit on its last pixel, 0-cycle compare.
// Never stalls: one pixel per en beat, clr restarts every counter while still counting the current beat.
module cell_accumulator
   import nn_pkg::*;
#(
   parameter int SCALE       = 8,
   parameter int CELL_THRESH = 32
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       clr,
   input  logic                       en,
   input  logic [$clog2(IMG_DIM)-1:0] col,
   input  logic                       ink,
   input  logic                       last_in_cell,
   output logic                       bit_val,
   output logic                       bit_we
);
   localparam int CNT_W = $clog2(SCALE * SCALE + 1);
   localparam int COL_W = $clog2(IMG_DIM);

   logic [CNT_W-1:0] colcnt [IMG_DIM];
   logic [CNT_W-1:0] sum;

   // A restart pixel starts a fresh count rather than adding to stale contents.
   assign sum     = (clr ? '0 : colcnt[col]) + CNT_W'(ink);
   assign bit_val = (sum >= CNT_W'(CELL_THRESH));
   assign bit_we  = en & last_in_cell;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         for (int i = 0; i < IMG_DIM; i++) colcnt[i] <= '0;
      end else begin
         for (int i = 0; i < IMG_DIM; i++) begin
            if (en && col == COL_W'(i))
               colcnt[i] <= last_in_cell ? '0 : sum;
            else if (clr)
               colcnt[i] <= '0;
         end
      end
   end
endmodule

// File: rtl/nn_image_capture.sv
// Thresholds and majority-downsamples a raster frame into a 28x28 bitmap, starts the network, latches its digit.
// nn_start one cycle after the last accepted beat, digit one cycle after nn_resp; pixel stream is never stalled.
module nn_image_capture
   import nn_pkg::*;
#(
   parameter int         SCALE       = 8,
   parameter logic [7:0] PIX_THRESH  = 8'd128,
   parameter int         CELL_THRESH = 32,
   parameter int         TIMEOUT     = 4096
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                capture_req,
   input  logic                pix_valid,
   input  logic                pix_sof,
   input  logic [7:0]          pix_data,
   output logic [IMG_BITS-1:0] nn_data,
   output logic                nn_start,
   input  logic                nn_resp,
   input  logic [PRED_W-1:0]   nn_prediction,
   output logic [PRED_W-1:0]   digit,
   output logic                digit_valid,
   output logic                busy,
   output logic                timeout_err
);
   localparam int SRC_DIM = IMG_DIM * SCALE;
   localparam int XY_W    = $clog2(SRC_DIM);
   localparam int WAIT_W  = $clog2(TIMEOUT + 1);
   localparam int COL_W   = $clog2(IMG_DIM);
   localparam int IDX_W   = $clog2(IMG_BITS);

   cap_state_t        state, state_nxt;
   logic [XY_W-1:0]   x, y, cur_x, cur_y;
   logic [WAIT_W-1:0] wait_cnt;
   logic [COL_W-1:0]  col, row;
   logic [IDX_W-1:0]  bit_idx;
   logic              take, restart, ink, x_last, y_last, frame_end, last_in_cell;
   logic              bit_val, bit_we, wait_expired;
   int                cx, cy;

   // Accept pixels only inside a frame; ARMED waits for the first sof.
   assign take    = pix_valid && ((state == ST_ARMED && pix_sof) || state == ST_CAPTURE);
   assign restart = take && pix_sof;
   assign cur_x   = pix_sof ? '0 : x;
   assign cur_y   = pix_sof ? '0 : y;
   assign ink     = (pix_data >= PIX_THRESH);

   always_comb begin
      cx           = 32'(cur_x);
      cy           = 32'(cur_y);
      col          = COL_W'(cx / SCALE);
      row          = COL_W'(cy / SCALE);
      last_in_cell = ((cx % SCALE) == SCALE - 1) && ((cy % SCALE) == SCALE - 1);
      x_last       = (cx == SRC_DIM - 1);
      y_last       = (cy == SRC_DIM - 1);
      frame_end    = x_last && y_last;
      bit_idx      = IDX_W'(32'(row) * IMG_DIM + 32'(col));
   end

   assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));

   cell_accumulator #(
      .SCALE       (SCALE),
      .CELL_THRESH (CELL_THRESH)
   ) u_cells (
      .Clk          (Clk),
      .Rst          (Rst),
      .clr          (restart),
      .en           (take),
      .col          (col),
      .ink          (ink),
      .last_in_cell (last_in_cell),
      .bit_val      (bit_val),
      .bit_we       (bit_we)
   );

   always_ff @(posedge Clk) begin
      if (!Rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (capture_req) state_nxt = ST_ARMED;
         ST_ARMED:   if (take) state_nxt = ST_CAPTURE;
         ST_CAPTURE: if (take && frame_end) state_nxt = ST_START;
         ST_START:   state_nxt = ST_WAIT_NN;
         ST_WAIT_NN: if (nn_resp || wait_expired) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         x           <= '0;
         y           <= '0;
         wait_cnt    <= '0;
         nn_data     <= '0;
         digit       <= '0;
         digit_valid <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (take) begin
            if (x_last) begin
               x <= '0;
               y <= y_last ? '0 : cur_y + 1'b1;
            end else begin
               x <= cur_x + 1'b1;
               y <= cur_y;
            end
         end
         if (bit_we) nn_data[bit_idx] <= bit_val;

         wait_cnt <= (state == ST_WAIT_NN) ? wait_cnt + 1'b1 : '0;

         if (state == ST_IDLE && capture_req) begin
            digit_valid <= 1'b0;
            timeout_err <= 1'b0;
         end
         // A response arriving on the expiry cycle still counts as success.
         if (state == ST_WAIT_NN) begin
            if (nn_resp) begin
               digit       <= nn_prediction;
               digit_valid <= 1'b1;
            end else if (wait_expired) begin
               timeout_err <= 1'b1;
            end
         end
      end
   end

   assign nn_start = (state == ST_START);
   assign busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_nn_image_capture.sv
// Directed bench for nn_image_capture at a reduced scale (2x2 cells, 3-of-4 majority).
// Expected bitmaps come from constants or an independent per-cell ink-count model.
module tb_nn_image_capture;
   localparam int SC  = 2;
   localparam int CT  = 3;
   localparam int TO  = 4096;
   localparam int SD  = 28 * SC;
   localparam int NPX = SD * SD;

   logic         Clk = 1'b0;
   logic         Rst;
   logic         capture_req, pix_valid, pix_sof, nn_resp;
   logic [7:0]   pix_data;
   logic [783:0] nn_data;
   logic         nn_start, digit_valid, busy, timeout_err;
   logic [4:0]   nn_prediction, digit;

   int n_chk = 0;
   int n_pass = 0;
   int start_cnt = 0;
   int s0;
   logic [783:0] exp_bm;

   nn_image_capture #(
      .SCALE(SC), .PIX_THRESH(8'd128), .CELL_THRESH(CT), .TIMEOUT(TO)
   ) dut (
      .Clk(Clk), .Rst(Rst), .capture_req(capture_req), .pix_valid(pix_valid),
      .pix_sof(pix_sof), .pix_data(pix_data), .nn_data(nn_data), .nn_start(nn_start),
      .nn_resp(nn_resp), .nn_prediction(nn_prediction), .digit(digit),
      .digit_valid(digit_valid), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) if (nn_start === 1'b1) start_cnt <= start_cnt + 1;

   task automatic chk(input string tag, input logic [783:0] got, input logic [783:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [7:0] pix_of(input int mode, input int x, input int y);
      case (mode)
         0: return 8'd0;
         1: return 8'd255;
         2: begin
            // cell (3,5): 3 inks incl. its last pixel; cell (3,6): 2 inks; cell (4,5): 3 inks
            if ((x == 10 && y == 6) || (x == 11 && y == 6) || (x == 11 && y == 7) ||
                (x == 12 && y == 6) || (x == 13 && y == 7) ||
                (x == 10 && y == 8) || (x == 11 && y == 8) || (x == 10 && y == 9))
               return 8'd128;
            return 8'd127;
         end
         3: return (x >= y) ? 8'd200 : 8'd50;
         default: return 8'd0;
      endcase
   endfunction

   function automatic logic [783:0] model(input int mode);
      logic [783:0] bm = '0;
      for (int r = 0; r < 28; r++)
         for (int c = 0; c < 28; c++) begin
            int cnt = 0;
            for (int dy = 0; dy < SC; dy++)
               for (int dx = 0; dx < SC; dx++)
                  if (pix_of(mode, c*SC + dx, r*SC + dy) >= 8'd128) cnt++;
            bm[r*28 + c] = (cnt >= CT);
         end
      return bm;
   endfunction

   task automatic send_frame(input int mode, input bit gaps, input int npix);
      for (int i = 0; i < npix; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
               pix_valid = 1'b0;
               pix_sof   = 1'($urandom_range(0, 1));
               pix_data  = 8'($urandom_range(0, 255));
               cyc();
            end
         end
         pix_valid = 1'b1;
         pix_sof   = (i == 0);
         pix_data  = pix_of(mode, i % SD, i / SD);
         cyc();
      end
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic req();
      capture_req = 1'b1;
      cyc();
      capture_req = 1'b0;
   endtask

   task automatic resp(input logic [4:0] pred);
      nn_prediction = pred;
      nn_resp = 1'b1;
      cyc();
      nn_resp = 1'b0;
      nn_prediction = 5'd31;
   endtask

   initial begin
      Rst = 1'b0; capture_req = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
      pix_data = 8'd0; nn_resp = 1'b0; nn_prediction = 5'd0;
      cyc(); cyc();
      Rst = 1'b1;
      chk("rst_nn_data", nn_data, '0);
      chk("rst_nn_start", nn_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_digit", digit, 0);
      chk("rst_digit_valid", digit_valid, 0);
      chk("rst_timeout_err", timeout_err, 0);

      // all-ink frame, preceded by pre-sof pixels that must be dropped
      req();
      chk("armed_busy", busy, 1);
      for (int i = 0; i < 5; i++) begin
         pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 8'd0; cyc();
      end
      send_frame(1, 0, NPX);
      chk("ones_start_latency", nn_start, 1);
      chk("ones_bitmap", nn_data, {784{1'b1}});
      cyc();
      chk("ones_start_width", nn_start, 0);
      chk("ones_wait_busy", busy, 1);
      cyc();
      chk("ones_no_early_valid", digit_valid, 0);
      resp(5'd7);
      chk("ones_digit", digit, 7);
      chk("ones_digit_valid", digit_valid, 1);
      chk("ones_idle", busy, 0);

      // blank frame then no response: timeout
      req();
      chk("req_clears_valid", digit_valid, 0);
      send_frame(0, 0, NPX);
      chk("zeros_start", nn_start, 1);
      chk("zeros_bitmap", nn_data, '0);
      for (int i = 0; i < 4000; i++) cyc();
      chk("to_still_waiting", busy, 1);
      for (int i = 0; i < 300 && busy; i++) cyc();
      chk("to_returns_idle", busy, 0);
      chk("to_err", timeout_err, 1);
      chk("to_digit_valid", digit_valid, 0);
      chk("to_digit_kept", digit, 7);
      req();
      chk("req_clears_to_err", timeout_err, 0);

      // threshold boundaries: pixel 128 vs 127, cell 3 vs 2 inks
      send_frame(2, 0, NPX);
      exp_bm = '0;
      exp_bm[89] = 1'b1;
      exp_bm[117] = 1'b1;
      chk("cells_bitmap", nn_data, exp_bm);
      chk("cells_bit89", nn_data[89], 1);
      chk("cells_bit90", nn_data[90], 0);
      cyc();
      req();
      chk("req_ignored_in_wait", busy, 1);
      resp(5'd3);
      chk("cells_digit", digit, 3);
      cyc();
      chk("cells_stays_idle", busy, 0);
      chk("cells_valid_held", digit_valid, 1);

      // diagonal frame with random bubbles
      req();
      send_frame(3, 1, NPX);
      chk("diag_gaps_start", nn_start, 1);
      chk("diag_gaps_bitmap", nn_data, model(3));
      chk("diag_corner", nn_data[27], 1);
      cyc();
      resp(5'd12);
      chk("diag_digit", digit, 12);

      // sof restart partway through a frame
      req();
      s0 = start_cnt;
      send_frame(0, 0, 1000);
      send_frame(1, 0, NPX);
      chk("restart_bitmap", nn_data, {784{1'b1}});
      cyc(); cyc(); cyc();
      chk("restart_single_start", start_cnt - s0, 1);
      resp(5'd9);
      chk("restart_digit", digit, 9);

      // reset in the middle of capture
      req();
      s0 = start_cnt;
      send_frame(1, 0, 500);
      Rst = 1'b0;
      cyc();
      Rst = 1'b1;
      chk("midcap_rst_data", nn_data, '0);
      chk("midcap_rst_busy", busy, 0);
      chk("midcap_rst_digit", digit, 0);
      chk("midcap_rst_valid", digit_valid, 0);
      for (int i = 0; i < 200; i++) begin
         pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 8'd255; cyc();
      end
      pix_valid = 1'b0;
      chk("midcap_no_start", start_cnt - s0, 0);
      chk("midcap_idle", busy, 0);

      // reset while waiting for the network
      req();
      send_frame(3, 0, NPX);
      chk("diag_bitmap", nn_data, model(3));
      for (int i = 0; i < 5; i++) cyc();
      Rst = 1'b0;
      cyc();
      Rst = 1'b1;
      chk("wait_rst_data", nn_data, '0);
      chk("wait_rst_busy", busy, 0);
      chk("wait_rst_start", nn_start, 0);
      chk("wait_rst_err", timeout_err, 0);
      s0 = start_cnt;
      for (int i = 0; i < 10; i++) cyc();
      chk("wait_rst_no_start", start_cnt - s0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/nn_image_capture.md
Name: nn_image_capture

Overview:
Front-end stage that feeds the digit-classifier network. It takes a raster grayscale pixel stream from the drawing canvas and thresholds each pixel. It downsamples by majority vote into the 28x28 binary bitmap the network consumes. It then pulses the network's start, waits for its response and latches the predicted digit for the display logic.

Parameters:
SCALE, 8, source pixels per cell edge; source frame is (28*SCALE) x (28*SCALE)
PIX_THRESH, 8'd128, grayscale level at or above which a source pixel counts as ink
CELL_THRESH, 32, ink-pixel count (of SCALE*SCALE) at or above which a cell bit is 1
TIMEOUT, 4096, cycles to wait for nn_resp before aborting

Ports:
Clk  input  1  clock
Rst  input  1  reset, synchronous, active-low
capture_req  input  1  one-cycle request to classify the next frame
pix_valid  input  1  pix_data/pix_sof valid this cycle; stream cannot be stalled
pix_sof  input  1  first pixel of a frame (raster order, row-major)
pix_data  input  8  grayscale pixel
nn_data  output  784  bitmap to network, bit index = row*28 + col
nn_start  output  1  one-cycle start pulse to network
nn_resp  input  1  network done (one cycle)
nn_prediction  input  5  network argmax result, valid when nn_resp=1
digit  output  5  latched prediction
digit_valid  output  1  high from latch until next capture_req accepted
busy  output  1  high in any state except IDLE
timeout_err  output  1  sticky; set on timeout, cleared by accepted capture_req

Behaviour:
- Reset (Rst=0 at a Clk edge): state IDLE. nn_data=0, nn_start=0, digit=0, digit_valid=0, timeout_err=0. All counters and x/y cleared. Reset mid-frame or mid-wait aborts without pulsing nn_start.
- States: IDLE, ARMED, CAPTURE, START, WAIT_NN.
- IDLE: capture_req -> ARMED. Same edge clears digit_valid and timeout_err. capture_req in any other state is ignored.
- ARMED: pix_valid&pix_sof -> CAPTURE. That pixel is processed as x=0,y=0 on the same edge. Pixels before sof are discarded.
- CAPTURE: each pix_valid beat advances x (0..28*SCALE-1), wrapping x to 0 and incrementing y. pix_valid=0 cycles hold everything.
- Ink rule: ink = (pix_data >= PIX_THRESH).
- Cell counters: per-column bank colcnt[0..27], width $clog2(SCALE*SCALE+1). colcnt[x/SCALE] += ink.
- Cell bit resolution: on the last pixel of a cell (x%SCALE==SCALE-1 and y%SCALE==SCALE-1), write nn_data[(y/SCALE)*28 + x/SCALE] = (colcnt+ink >= CELL_THRESH). The counter clears to 0 on the same edge.
- pix_sof during CAPTURE restarts the frame: counters cleared, x=y=0, that pixel counted. Bits already written are overwritten as the new frame proceeds.
- Frame end: the beat at x=y=28*SCALE-1 -> START.
- START: nn_start=1 for exactly one cycle -> WAIT_NN. nn_data is frozen from START until the next CAPTURE entry.
- WAIT_NN: the wait counter increments every cycle. Pixel stream ignored, including sof.
  - nn_resp: digit<=nn_prediction, digit_valid<=1 -> IDLE.
  - Counter reaching TIMEOUT without nn_resp: timeout_err<=1, digit unchanged -> IDLE.
  - nn_resp on the same cycle as timeout: resp wins.
- Latency: nn_start asserts the cycle after the final pixel beat is accepted. digit_valid rises the cycle after nn_resp.
- Widths: x,y are $clog2(28*SCALE) bits; the wait counter is $clog2(TIMEOUT+1) bits.

Decomposition:
- Package nn_pkg: IMG_DIM=28, IMG_BITS=784, capture state enum typedef, prediction width constant 5.
- Sub-module cell_accumulator: the 28-entry column counter bank with increment/clear/compare. Inputs col, ink, last_in_cell, en; outputs bit_val, bit_we.

Test Plan:
- SCALE=8: all-255 frame after capture_req -> nn_data all 1s; nn_start one cycle after the last beat. nn_resp with prediction=7 -> digit=7, digit_valid=1, state IDLE.
- All-0 frame -> nn_data all 0s. Frame with only cell (row 3, col 5) at 33 ink pixels -> only bit 89 set. Same cell at 31 ink pixels -> bit 89 clear.
- pix_valid toggled 50% randomly across a frame with a diagonal pattern -> nn_data identical to the gapless run.
- sof re-asserted at pixel 1000 of a frame, then a full all-255 frame -> single nn_start, all 1s.
- No nn_resp for 4096 cycles after nn_start -> timeout_err=1, digit_valid=0, IDLE. Next capture_req clears timeout_err.
- Rst=0 asserted mid-CAPTURE and during WAIT_NN -> every output at its reset value next edge, no nn_start. capture_req during WAIT_NN -> ignored.
